ides8_align_ctrl: RTL and testbench

Word-alignment (bitslip) controller for one IDES8 deserializer lane. During link training it watches the parallel word on the PCLK domain and pulses the deserializer CALIB input until the received word equals a known training pattern. It then reports lock, or failure after every slip position has been tried. One instance sits per receive lane, between the IDES8 outputs and the lane-bonding/correlator front end.

---
 rtl/ides8_align_pkg.sv | 29 ++
 rtl/ides8_align_ctrl.sv | 122 ++++++++++++
 tb/tb_ides8_align_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ides8_align_pkg.sv
// Shared types and constants for the IDES8 word-alignment controller.
package ides8_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_SLIP,
    ST_LOCKED,
    ST_FAIL
  } align_state_e;

  localparam logic [7:0] DEFAULT_TRAIN_PATTERN = 8'h5C;

  // A pattern is only usable if no non-trivial rotation reproduces it,
  // otherwise two slip positions would both look aligned.
  function automatic logic rotations_unique(input logic [7:0] pattern);
    logic [7:0] rot;
    logic       ok;
    ok  = 1'b1;
    rot = pattern;
    for (int r = 1; r < 8; r++) begin
      rot = {rot[6:0], rot[7]};
      if (rot == pattern) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/ides8_align_ctrl.sv
// Bitslip controller for one IDES8 lane: pulses CALIB until the parallel
// word matches the training pattern, then reports lock or failure.
module ides8_align_ctrl
  import ides8_align_pkg::*;
#(
  parameter logic [7:0] TRAIN_PATTERN = DEFAULT_TRAIN_PATTERN,
  parameter int         SETTLE_CYCLES = 4,
  parameter int         MATCH_COUNT   = 16,
  parameter int         NUM_POS       = 8
) (
  input  logic       PCLK,
  input  logic       RESET,
  input  logic       start,
  input  logic [7:0] rx_word,
  output logic       calib,
  output logic       busy,
  output logic       locked,
  output logic       fail,
  output logic [2:0] slip_count
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] MATCH_LAST  = 8'(MATCH_COUNT - 1);
  localparam logic [3:0] POS_LIMIT   = 4'(NUM_POS);
  localparam logic [2:0] FAIL_SLIPS  = 3'(NUM_POS % 8);

  if (!rotations_unique(TRAIN_PATTERN)) begin : g_bad_pattern
    $error("TRAIN_PATTERN rotations are not all distinct");
  end
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES out of range 1..15");
  end
  if (MATCH_COUNT < 1 || MATCH_COUNT > 255) begin : g_bad_match
    $error("MATCH_COUNT out of range 1..255");
  end
  if (NUM_POS < 1 || NUM_POS > 8) begin : g_bad_pos
    $error("NUM_POS out of range 1..8");
  end

  align_state_e state, state_n;
  logic [3:0]   settle_cnt, settle_n;
  logic [7:0]   match_cnt, match_n;
  logic [2:0]   slip_n;
  logic         calib_n, busy_n, locked_n, fail_n;

  always_ff @(posedge PCLK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      match_cnt  <= '0;
      slip_count <= '0;
      calib      <= 1'b0;
      busy       <= 1'b0;
      locked     <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state      <= state_n;
      settle_cnt <= settle_n;
      match_cnt  <= match_n;
      slip_count <= slip_n;
      calib      <= calib_n;
      busy       <= busy_n;
      locked     <= locked_n;
      fail       <= fail_n;
    end
  end

  // rx_word is only examined in CHECK, so garbage during SETTLE or LOCKED
  // never reaches the state or the outputs.
  always_comb begin
    state_n  = state;
    settle_n = settle_cnt;
    match_n  = match_cnt;
    slip_n   = slip_count;

    case (state)
      ST_IDLE, ST_LOCKED, ST_FAIL: begin
        if (start) begin
          state_n  = ST_SETTLE;
          settle_n = SETTLE_LOAD;
          slip_n   = '0;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == '0) begin
          state_n = ST_CHECK;
          match_n = '0;
        end else begin
          settle_n = settle_cnt - 4'd1;
        end
      end
      ST_CHECK: begin
        if (rx_word == TRAIN_PATTERN) begin
          if (match_cnt == MATCH_LAST) state_n = ST_LOCKED;
          else                         match_n = match_cnt + 8'd1;
        end else begin
          match_n = '0;
          if (({1'b0, slip_count} + 4'd1) < POS_LIMIT) begin
            state_n = ST_SLIP;
          end else begin
            state_n = ST_FAIL;
            slip_n  = FAIL_SLIPS;
          end
        end
      end
      ST_SLIP: begin
        state_n  = ST_SETTLE;
        settle_n = SETTLE_LOAD;
        slip_n   = slip_count + 3'd1;
      end
      default: state_n = ST_IDLE;
    endcase

    // Outputs are registered from the next state so each one tracks its
    // state exactly, with calib confined to the single SLIP cycle.
    calib_n  = (state_n == ST_SLIP);
    busy_n   = (state_n == ST_SETTLE) || (state_n == ST_CHECK) || (state_n == ST_SLIP);
    locked_n = (state_n == ST_LOCKED);
    fail_n   = (state_n == ST_FAIL);
  end

endmodule

// File: tb/tb_ides8_align_ctrl.sv
// Scoreboard bench for ides8_align_ctrl with a rotating IDES8 lane model.
module tb_ides8_align_ctrl;

  localparam logic [7:0] TRAIN = 8'h5C;

  typedef enum {MODE_ROTATE, MODE_ZERO, MODE_FIXED} rx_mode_e;

  typedef struct {
    string      name;
    int         latency;
    int         pulses;
    logic       locked;
    logic       fail;
    logic [2:0] slips;
  } exp_t;

  logic       PCLK;
  logic       RESET;
  logic       start;
  logic [7:0] rx_word;
  logic       calib;
  logic       busy;
  logic       locked;
  logic       fail;
  logic [2:0] slip_count;

  rx_mode_e   mode = MODE_ROTATE;
  logic       noise = 1'b0;
  logic       xinj = 1'b0;
  logic [2:0] rot_base = 3'd0;
  logic [2:0] calib_total = 3'd0;
  logic [2:0] rot_idx;

  int   cyc = 0;
  int   start_edge = 0;
  int   run_tag = 0;
  int   seen_tag = 0;
  int   pulses = 0;
  int   last_pulse = 0;
  logic prev_calib = 1'b0;
  logic prev_done = 1'b0;
  exp_t exp_q[$];

  int assert_count = 0;
  int fail_count = 0;

  ides8_align_ctrl dut (
    .PCLK       (PCLK),
    .RESET      (RESET),
    .start      (start),
    .rx_word    (rx_word),
    .calib      (calib),
    .busy       (busy),
    .locked     (locked),
    .fail       (fail),
    .slip_count (slip_count)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] rotl8(input logic [7:0] p, input logic [2:0] r);
    logic [15:0] t;
    t = {p, p} << r;
    return t[15:8];
  endfunction

  // Lane model: each CALIB pulse seen by the deserializer advances the word
  // rotation by one bit.
  always @(posedge PCLK) begin
    cyc <= cyc + 1;
    if (calib === 1'b1) calib_total <= calib_total + 3'd1;
  end

  assign rot_idx = rot_base + calib_total;
  assign rx_word = xinj  ? 8'hxx :
                   noise ? ~TRAIN :
                   (mode == MODE_ZERO)  ? 8'h00 :
                   (mode == MODE_FIXED) ? TRAIN :
                   rotl8(TRAIN, rot_idx);

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic exp_t mkExp(input string n, input int lat, input int pul,
                                 input logic l, input logic f, input logic [2:0] s);
    exp_t e;
    e.name = n; e.latency = lat; e.pulses = pul;
    e.locked = l; e.fail = f; e.slips = s;
    return e;
  endfunction

  // Pulse-shape checks plus scoreboard pop whenever a run finishes.
  always @(negedge PCLK) begin
    exp_t e;
    if (run_tag != seen_tag) begin
      seen_tag = run_tag;
      pulses   = 0;
    end
    if (calib === 1'b1) begin
      checkOutput("calib_width", 32'(prev_calib), 32'd0);
      if (pulses > 0) checkOutput("pulse_gap", 32'(cyc - last_pulse), 32'd6);
      last_pulse = cyc;
      pulses++;
    end
    if ((locked === 1'b1 || fail === 1'b1) && !prev_done && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput({e.name, "_locked"},  32'(locked), 32'(e.locked));
      checkOutput({e.name, "_fail"},    32'(fail), 32'(e.fail));
      checkOutput({e.name, "_busy"},    32'(busy), 32'd0);
      checkOutput({e.name, "_slips"},   32'(slip_count), 32'(e.slips));
      checkOutput({e.name, "_pulses"},  32'(pulses), 32'(e.pulses));
      checkOutput({e.name, "_latency"}, 32'(cyc - start_edge), 32'(e.latency));
    end
    prev_calib = (calib === 1'b1);
    prev_done  = (locked === 1'b1) || (fail === 1'b1);
  end

  task automatic setRot(input logic [2:0] r);
    rot_base = r - calib_total;
  endtask

  task automatic applyStimulus(input exp_t e, input bit track);
    @(negedge PCLK);
    start      = 1'b1;
    start_edge = cyc;
    run_tag++;
    if (track) exp_q.push_back(e);
    @(negedge PCLK);
    start = 1'b0;
    checkOutput({e.name, "_busy_start"}, 32'(busy), 32'd1);
    checkOutput({e.name, "_locked_clr"}, 32'(locked), 32'd0);
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge PCLK);
      n++;
    end
    checkOutput("done_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_calib"}, 32'(calib), 32'd0);
    checkOutput({tag, "_busy"},  32'(busy), 32'd0);
    checkOutput({tag, "_locked"}, 32'(locked), 32'd0);
    checkOutput({tag, "_fail"},  32'(fail), 32'd0);
    checkOutput({tag, "_slips"}, 32'(slip_count), 32'd0);
  endtask

  initial begin
    int seen;
    RESET = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge PCLK);
    checkResetState("reset");
    RESET = 1'b0;

    $display("[TB] aligned at start");
    mode = MODE_ROTATE;
    setRot(3'd0);
    applyStimulus(mkExp("aligned", 21, 0, 1'b1, 1'b0, 3'd0), 1'b1);
    waitDone(300);

    $display("[TB] misaligned by 3, X on rx_word while settling");
    setRot(3'd5);
    applyStimulus(mkExp("misalign3", 39, 3, 1'b1, 1'b0, 3'd3), 1'b1);
    xinj = 1'b1;
    repeat (3) @(negedge PCLK);
    xinj = 1'b0;
    checkOutput("x_settle_outputs", 32'({calib, busy, locked, fail, slip_count}), 32'b0100000);
    waitDone(300);

    $display("[TB] no pattern");
    mode = MODE_ZERO;
    applyStimulus(mkExp("nopattern", 48, 7, 1'b0, 1'b1, 3'd0), 1'b1);
    waitDone(300);
    repeat (12) @(negedge PCLK);
    checkOutput("nopattern_no_8th_pulse", 32'(pulses), 32'd7);
    checkOutput("nopattern_fail_held", 32'(fail), 32'd1);

    $display("[TB] noise at match 10");
    mode = MODE_FIXED;
    applyStimulus(mkExp("noise", 36, 1, 1'b1, 1'b0, 3'd1), 1'b1);
    repeat (13) @(negedge PCLK);
    noise = 1'b1;
    @(negedge PCLK);
    noise = 1'b0;
    waitDone(300);

    $display("[TB] reset during slip");
    mode = MODE_ZERO;
    applyStimulus(mkExp("rstslip", 0, 0, 1'b0, 1'b0, 3'd0), 1'b0);
    seen = 0;
    for (int n = 0; n < 100 && seen < 2; n++) begin
      @(negedge PCLK);
      if (calib === 1'b1) seen++;
    end
    checkOutput("rstslip_reached", 32'(seen), 32'd2);
    RESET = 1'b1;
    @(negedge PCLK);
    checkResetState("rstslip");
    RESET = 1'b0;
    mode = MODE_ROTATE;
    setRot(3'd0);
    applyStimulus(mkExp("restart", 21, 0, 1'b1, 1'b0, 3'd0), 1'b1);
    waitDone(300);

    $display("[TB] start while busy, then start while locked");
    setRot(3'd0);
    applyStimulus(mkExp("busystart", 21, 0, 1'b1, 1'b0, 3'd0), 1'b1);
    start = 1'b1;
    @(negedge PCLK);
    start = 1'b0;
    waitDone(300);
    setRot(3'd7);
    applyStimulus(mkExp("relock", 27, 1, 1'b1, 1'b0, 3'd1), 1'b1);
    waitDone(300);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
